// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and the fault-injection/readback engine (port 1), with bounded locked bursts.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam int unsigned     CntW     = $clog2(MAX_LOCK + 1);
   localparam logic [CntW-1:0] LockLast = CntW'(MAX_LOCK - 1);
   localparam bit              LockEn   = (MAX_LOCK > 1);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e          state;
   logic            rr_ptr;
   logic [CntW-1:0] lock_cnt;
   logic            xfer0;
   logic            xfer1;

   // Grants depend only on state, rr_ptr and the requests.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         case (state)
            StIdle: begin
               gnt0 = req0 && (!req1 || !rr_ptr);
               gnt1 = req1 && (!req0 || rr_ptr);
            end
            StOwn0:  gnt0 = 1'b1;
            StOwn1:  gnt1 = 1'b1;
            default: ;
         endcase
      end
   end

   assign xfer0 = req0 && gnt0;
   assign xfer1 = req1 && gnt1;

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (xfer0) begin
         mem_we = we0;
         mem_a  = addr0;
         mem_wd = wdata0;
      end else if (xfer1) begin
         mem_we = we1;
         mem_a  = addr1;
         mem_wd = wdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         rr_ptr   <= 1'b0;
         lock_cnt <= '0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         done0 <= xfer0;
         done1 <= xfer1;
         if (xfer0 && !we0) rdata0 <= mem_rd;
         if (xfer1 && !we1) rdata1 <= mem_rd;

         case (state)
            StIdle: begin
               if (xfer0) begin
                  if (lock0 && LockEn) begin
                     state    <= StOwn0;
                     lock_cnt <= CntW'(1);
                  end else begin
                     rr_ptr <= 1'b1;
                  end
               end else if (xfer1) begin
                  if (lock1 && LockEn) begin
                     state    <= StOwn1;
                     lock_cnt <= CntW'(1);
                  end else begin
                     rr_ptr <= 1'b0;
                  end
               end
            end
            StOwn0: begin
               if (req0 && lock0 && (lock_cnt < LockLast)) begin
                  lock_cnt <= lock_cnt + 1'b1;
               end else begin
                  // Final transfer or dropped request: hand priority to the waiter.
                  state    <= StIdle;
                  rr_ptr   <= 1'b1;
                  lock_cnt <= '0;
               end
            end
            StOwn1: begin
               if (req1 && lock1 && (lock_cnt < LockLast)) begin
                  lock_cnt <= lock_cnt + 1'b1;
               end else begin
                  state    <= StIdle;
                  rr_ptr   <= 1'b0;
                  lock_cnt <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter with a small behavioural memory.
module tb_dmem_port_arbiter;

   localparam logic [31:0] A = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, lock0, lock1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, mem_we;
   logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
   logic [31:0] mem [64];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MAX_LOCK(4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .req1  (req1),
      .lock0 (lock0),
      .lock1 (lock1),
      .we0   (we0),
      .we1   (we1),
      .addr0 (addr0),
      .addr1 (addr1),
      .wdata0(wdata0),
      .wdata1(wdata1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .done0 (done0),
      .done1 (done1),
      .rdata0(rdata0),
      .rdata1(rdata1),
      .mem_we(mem_we),
      .mem_a (mem_a),
      .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   // Memory model: word i holds A+i, except word 28 which holds 0x20.
   assign mem_rd = mem[mem_a[5:0]];
   always @(posedge clk) begin
      if (rst && !dut.state[0] && !dut.state[1] && n_total == 0) begin
         for (int i = 0; i < 64; i++) mem[i] <= (i == 28) ? 32'h20 : (A + 32'(i));
      end else if (mem_we) begin
         mem[mem_a[5:0]] <= mem_wd;
      end
   end

   typedef struct {
      logic        rst, r0, r1, l0, l1, w0, w1;
      logic [31:0] a0, a1, wd0, wd1;
      logic        g0, g1, mwe;
      logic [31:0] ma, mwd;
      logic        d0, d1;
      logic [31:0] rd0, rd1;
   } vec_t;

   function automatic vec_t mk(
      logic rs, logic r0, logic r1, logic l0, logic l1, logic w0, logic w1,
      logic [31:0] a0, logic [31:0] a1, logic [31:0] wd0, logic [31:0] wd1,
      logic g0, logic g1, logic mwe, logic [31:0] ma, logic [31:0] mwd,
      logic d0, logic d1, logic [31:0] rd0, logic [31:0] rd1);
      vec_t v;
      v.rst = rs; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
      v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
      v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
      v.d0 = d0; v.d1 = d1; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      rst = v.rst; req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
      we0 = v.w0; we1 = v.w1; addr0 = v.a0; addr1 = v.a1; wdata0 = v.wd0; wdata1 = v.wd1;
      #2;
   endtask

   vec_t vecs[23];
   vec_t v;

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset held with both requesting and a pending write.
      for (int i = 0; i < 3; i++)
         vecs[i] = mk(1,1,1,0,0,1,0, 3,4,32'h11,0,  0,0,0,0,0, 0,0,0,0);
      // Single read of word 28, then a write pass-through on port 1.
      vecs[3]  = mk(0,1,0,0,0,0,0, 28,0,0,0,  1,0,0,28,0, 0,0,0,0);
      vecs[4]  = mk(0,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0, 1,0,32'h20,0);
      vecs[5]  = mk(0,0,1,0,0,0,1, 0,5,0,32'hDEADBEEF, 0,1,1,5,32'hDEADBEEF, 0,0,32'h20,0);
      vecs[6]  = mk(0,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0, 0,1,32'h20,0);
      // Contention without lock: grants alternate.
      vecs[7]  = mk(0,1,1,0,0,0,0, 10,11,0,0, 1,0,0,10,0, 0,0,32'h20,0);
      vecs[8]  = mk(0,1,1,0,0,0,0, 10,11,0,0, 0,1,0,11,0, 1,0,A+10,0);
      vecs[9]  = mk(0,1,1,0,0,0,0, 10,11,0,0, 1,0,0,10,0, 0,1,A+10,A+11);
      vecs[10] = mk(0,1,1,0,0,0,0, 10,11,0,0, 0,1,0,11,0, 1,0,A+10,A+11);
      // Locked burst on port 0: four grants, then forced release to port 1.
      vecs[11] = mk(0,1,1,1,0,0,0, 12,13,0,0, 1,0,0,12,0, 0,1,A+10,A+11);
      vecs[12] = mk(0,1,1,1,0,0,0, 12,13,0,0, 1,0,0,12,0, 1,0,A+12,A+11);
      vecs[13] = mk(0,1,1,1,0,0,0, 12,13,0,0, 1,0,0,12,0, 1,0,A+12,A+11);
      vecs[14] = mk(0,1,1,1,0,0,0, 12,13,0,0, 1,0,0,12,0, 1,0,A+12,A+11);
      vecs[15] = mk(0,1,1,1,0,0,0, 12,13,0,0, 0,1,0,13,0, 1,0,A+12,A+11);
      // New locked ownership, then the owner drops req: one dead cycle.
      vecs[16] = mk(0,1,1,1,0,0,0, 12,13,0,0, 1,0,0,12,0, 0,1,A+12,A+13);
      vecs[17] = mk(0,0,1,1,0,0,0, 12,13,0,0, 1,0,0,0,0,  1,0,A+12,A+13);
      vecs[18] = mk(0,0,1,1,0,0,0, 12,13,0,0, 0,1,0,13,0, 0,0,A+12,A+13);
      vecs[19] = mk(0,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0,  0,1,A+12,A+13);
      // Port 0 write then read-back of the same word.
      vecs[20] = mk(0,1,0,0,0,1,0, 7,0,32'h12345678,0, 1,0,1,7,32'h12345678, 0,0,A+12,A+13);
      vecs[21] = mk(0,1,0,0,0,0,0, 7,0,0,0,   1,0,0,7,0,  1,0,A+12,A+13);
      vecs[22] = mk(0,0,0,0,0,0,0, 0,0,0,0,   0,0,0,0,0,  1,0,32'h12345678,A+13);

      @(posedge clk);
      for (int i = 0; i < 23; i++) begin
         drive(vecs[i]);
         check("gnt0",   i, 32'(gnt0),   32'(vecs[i].g0));
         check("gnt1",   i, 32'(gnt1),   32'(vecs[i].g1));
         check("mem_we", i, 32'(mem_we), 32'(vecs[i].mwe));
         check("mem_a",  i, mem_a,       vecs[i].ma);
         check("mem_wd", i, mem_wd,      vecs[i].mwd);
         check("done0",  i, 32'(done0),  32'(vecs[i].d0));
         check("done1",  i, 32'(done1),  32'(vecs[i].d1));
         check("rdata0", i, rdata0,      vecs[i].rd0);
         check("rdata1", i, rdata1,      vecs[i].rd1);
      end

      // Reset in the 2nd cycle of a locked port-1 burst, port 0 waiting (rr_ptr is 1 here).
      v = mk(0,1,1,0,1,0,0, 21,20,0,0, 0,0,0,0,0, 0,0,0,0);
      drive(v);
      check("burst1_gnt1", 100, 32'(gnt1), 32'd1);
      check("burst1_gnt0", 100, 32'(gnt0), 32'd0);
      v.rst = 1'b1; v.w1 = 1'b1; v.wd1 = 32'hFFFF_FFFF;
      drive(v);
      check("rst_gnt1",   101, 32'(gnt1),   32'd0);
      check("rst_gnt0",   101, 32'(gnt0),   32'd0);
      check("rst_mem_we", 101, 32'(mem_we), 32'd0);
      v.rst = 1'b0; v.w1 = 1'b0; v.wd1 = 32'h0;
      drive(v);
      check("post_gnt0",  102, 32'(gnt0),  32'd1);
      check("post_gnt1",  102, 32'(gnt1),  32'd0);
      check("post_mem_a", 102, mem_a,      32'd21);
      check("post_done1", 102, 32'(done1), 32'd0);
      check("post_rdata1", 102, rdata1,    32'd0);
      check("no_write",   102, mem[20],    A + 32'd20);
      drive(v);
      check("after_gnt1", 103, 32'(gnt1),  32'd1);
      check("after_done0", 103, 32'(done0), 32'd1);
      check("after_rdata0", 103, rdata0,   A + 32'd21);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single-port data memory between the core's load/store path (requester 0) and the fault-injection/readback engine (requester 1). It grants at most one transfer per cycle, uses round-robin priority, and supports locked bursts with a bounded lock length. Read data returns through per-requester registered response ports. The block sits between both masters and the data memory's WE/A/WD/RD pins.

## Interface
- `ADDR_W`, default 32: address width, passed to the memory unchanged.
- `DATA_W`, default 32: data width.
- `MAX_LOCK`, default 16: maximum transfers per locked ownership (≥1).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req0`, `req1`  in  1: transfer request.
- `lock0`, `lock1`  in  1: keep ownership after this transfer.
- `we0`, `we1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W: transfer address.
- `wdata0`, `wdata1`  in  DATA_W: write data.
- `gnt0`, `gnt1`  out  1: combinational grant; a transfer occurs in any cycle where `reqk && gntk`.
- `done0`, `done1`  out  1: one-cycle pulse in the cycle after requester k's transfer (read or write).
- `rdata0`, `rdata1`  out  DATA_W: registered read data; valid when `donek` is high after a read, and held otherwise.
- `mem_we`  out  1: memory write enable.
- `mem_a`  out  ADDR_W: memory address.
- `mem_wd`  out  DATA_W: memory write data.
- `mem_rd`  in  DATA_W: memory read data, combinational from `mem_a`.

## Operation
- State: FSM {IDLE, OWN0, OWN1}; `rr_ptr` (1 bit, requester that wins a tie); `lock_cnt` (width ⌈log2(MAX_LOCK+1)⌉).
- **IDLE:**
  - Winner is the sole requester, or `rr_ptr` if both request.
  - `gnt` goes high for the winner only, and the transfer happens in that cycle.
  - If the winner's lock is high and MAX_LOCK > 1: go to OWNk with `lock_cnt` = 1.
  - Otherwise stay in IDLE and set `rr_ptr` to the other requester.
  - No request: no grant, no state change.
- **OWNk:** `gntk` = 1, other grant = 0. The other requester waits regardless of its req.
  - `reqk && lockk && lock_cnt < MAX_LOCK−1`: transfer, `lock_cnt`++, stay in OWNk.
  - `reqk` and (`!lockk` or `lock_cnt` == MAX_LOCK−1): final transfer, go to IDLE, `rr_ptr` ← other.
  - `!reqk`: no transfer, go to IDLE, `rr_ptr` ← other.
- **Memory mux:** with a transfer by k, drive `mem_a` = `addrk`, `mem_wd` = `wdatak`, `mem_we` = `wek`. With no transfer, drive `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0.
- **Response:** on a read transfer by k, register `rdatak` ← `mem_rd`. On any transfer by k, register `donek` ← 1; otherwise `donek` ← 0.
- Grant is a pure function of state, `rr_ptr` and the req inputs. lock, we, addr and wdata never affect which requester is granted.

## Timing
- **Reset** (`rst` high at an edge): state = IDLE, `rr_ptr` = 0, `lock_cnt` = 0, `done0/1` = 0, `rdata0/1` = 0.
  - While `rst` is high, `gnt0/1` = 0 and `mem_we` = 0 combinationally. No transfer occurs during reset.
  - Reset asserted mid-burst abandons the ownership. Writes from the reset cycle are not issued.
- **Latency:** grant in the same cycle as the request when the block is free. `done`/`rdata` follow 1 cycle after the transfer. Throughput is 1 transfer per cycle.
- **Burst ownership:** a locked owner gets at most MAX_LOCK consecutive transfers. It is then forced back through IDLE with `rr_ptr` pointing to the other requester, so a waiting requester is granted within MAX_LOCK+1 cycles.
- **Owner drops req while locked:** costs one no-transfer cycle, then the block is back in IDLE.
- **Same-cycle events:** simultaneous req from both in IDLE resolves by `rr_ptr`. A requester that wins with lock=0 hands priority to the other requester in the next cycle.
- **MAX_LOCK = 1:** lock is ignored and the FSM never leaves IDLE.

## Test plan
- **Reset:** hold `rst` high 3 cycles with `req0` = `req1` = 1, `we0` = 1 → `gnt0/1` = 0, `mem_we` = 0, `done` = 0, `rdata` = 0 throughout.
- **Single read:**
  - Setup: memory word at address 28 = 0x20.
  - Stimulus: `req0`, `we0` = 0, `addr0` = 28 for 1 cycle.
  - Required response: `gnt0` = 1 in the same cycle, `mem_a` = 28; next cycle `done0` = 1, `rdata0` = 0x00000020; `done1` never pulses.
- **Contention:**
  - Stimulus: both request reads continuously, lock = 0, from reset.
  - Required response: grants alternate 0,1,0,1,…; each requester completes 1 transfer per 2 cycles.
- **Locked burst with forced release:**
  - Stimulus: MAX_LOCK = 4; `req0` and `lock0` held high; `req1` held high.
  - Required response: `gnt0` for 4 consecutive cycles, then `gnt1` in the 5th cycle.
- **Write pass-through:**
  - Stimulus: `req1`, `we1` = 1, `addr1` = 5, `wdata1` = 0xDEADBEEF.
  - Required response: same cycle `mem_we` = 1, `mem_a` = 5, `mem_wd` = 0xDEADBEEF; next cycle `done1` = 1 and `rdata1` unchanged.
- **Reset mid-burst:**
  - Stimulus: `rst` asserted in the 2nd cycle of a locked `req1` burst while `req0` is waiting.
  - Required response: after reset deasserts, `rr_ptr` = 0 and `gnt0` is granted first.
